// File: rtl/peripheral_msi_slave_port_apb4_if.sv
// peripheral_msi_slave_port_apb4_if: master-port fan-in and single AHB-Lite slave bus of one slave port
interface peripheral_msi_slave_port_apb4_if #(
  parameter int PLEN = 64,
  parameter int XLEN = 64,
  parameter int MASTERS = 5
);
  logic [MASTERS-1:0][2:0]      mst_priority;
  logic [MASTERS-1:0]           mst_HSEL;
  logic [MASTERS-1:0][PLEN-1:0] mst_HADDR;
  logic [MASTERS-1:0][XLEN-1:0] mst_HWDATA;
  logic [MASTERS-1:0]           mst_HWRITE;
  logic [MASTERS-1:0][2:0]      mst_HSIZE;
  logic [MASTERS-1:0][2:0]      mst_HBURST;
  logic [MASTERS-1:0][3:0]      mst_HPROT;
  logic [MASTERS-1:0][1:0]      mst_HTRANS;
  logic [MASTERS-1:0]           mst_HMASTLOCK;
  logic [MASTERS-1:0]           mst_HREADY;
  logic [MASTERS-1:0]           can_switch;
  logic [MASTERS-1:0]           master_granted;
  logic [XLEN-1:0]              mst_HRDATA;
  logic                         mst_HREADYOUT;
  logic                         mst_HRESP;
  logic                         slv_HSEL;
  logic [PLEN-1:0]              slv_HADDR;
  logic [XLEN-1:0]              slv_HWDATA;
  logic                         slv_HWRITE;
  logic [2:0]                   slv_HSIZE;
  logic [2:0]                   slv_HBURST;
  logic [3:0]                   slv_HPROT;
  logic [1:0]                   slv_HTRANS;
  logic                         slv_HMASTLOCK;
  logic                         slv_HREADY;
  logic [XLEN-1:0]              slv_HRDATA;
  logic                         slv_HREADYOUT;
  logic                         slv_HRESP;
  modport slave (
    input  mst_priority, mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE, mst_HBURST,
           mst_HPROT, mst_HTRANS, mst_HMASTLOCK, mst_HREADY, can_switch,
           slv_HRDATA, slv_HREADYOUT, slv_HRESP,
    output master_granted, mst_HRDATA, mst_HREADYOUT, mst_HRESP,
           slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
           slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADY
  );
  modport master (
    output mst_priority, mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE, mst_HBURST,
           mst_HPROT, mst_HTRANS, mst_HMASTLOCK, mst_HREADY, can_switch,
           slv_HRDATA, slv_HREADYOUT, slv_HRESP,
    input  master_granted, mst_HRDATA, mst_HREADYOUT, mst_HRESP,
           slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
           slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADY
  );
endinterface

// File: rtl/peripheral_msi_slave_port_apb4.sv
// peripheral_msi_slave_port_apb4: priority/round-robin arbiter and AHB-Lite mux in front of one slave
module peripheral_msi_slave_port_apb4 #(
  parameter int PLEN = 64,
  parameter int XLEN = 64,
  parameter int MASTERS = 5,
  parameter int SLAVES = 5
) (
  input logic HCLK,
  input logic HRESET,
  peripheral_msi_slave_port_apb4_if.slave bus
);
  localparam int IW = MASTERS > 1 ? $clog2(MASTERS) : 1;
  localparam logic [1:0] IDLE = 2'b00;
  if (SLAVES < 1) $error("SLAVES must be at least 1");
  logic [IW-1:0] gnt_idx, dph_idx, rr_ptr, win, c, sel;
  logic gnt_vld, dph_vld, found, switch_ok;
  logic [2:0] best;
  // strict '>' keeps the first candidate after rr_ptr on equal priority
  always_comb begin
    win = '0;
    best = '0;
    found = 1'b0;
    c = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      c = IW'((int'(rr_ptr) + k) % MASTERS);
      if (bus.mst_HSEL[c] && (!found || bus.mst_priority[c] > best)) begin
        win = c;
        best = bus.mst_priority[c];
        found = 1'b1;
      end
    end
  end
  assign switch_ok = !gnt_vld || !bus.mst_HSEL[gnt_idx] || bus.can_switch[gnt_idx];
  assign sel = gnt_vld ? gnt_idx : '0;
  assign bus.slv_HSEL = gnt_vld && bus.mst_HSEL[gnt_idx];
  assign bus.slv_HTRANS = gnt_vld ? bus.mst_HTRANS[gnt_idx] : IDLE;
  assign bus.slv_HADDR = bus.mst_HADDR[sel];
  assign bus.slv_HWRITE = bus.mst_HWRITE[sel];
  assign bus.slv_HSIZE = bus.mst_HSIZE[sel];
  assign bus.slv_HBURST = bus.mst_HBURST[sel];
  assign bus.slv_HPROT = bus.mst_HPROT[sel];
  assign bus.slv_HMASTLOCK = bus.mst_HMASTLOCK[sel];
  assign bus.slv_HWDATA = dph_vld ? bus.mst_HWDATA[dph_idx] : '0;
  assign bus.slv_HREADY = dph_vld ? bus.mst_HREADY[dph_idx] : 1'b1;
  assign bus.mst_HRDATA = bus.slv_HRDATA;
  assign bus.mst_HREADYOUT = bus.slv_HREADYOUT;
  assign bus.mst_HRESP = bus.slv_HRESP;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      dph_idx <= '0;
      dph_vld <= 1'b0;
      rr_ptr <= IW'(MASTERS - 1);
      bus.master_granted <= '0;
    end else if (bus.slv_HREADYOUT) begin
      if (switch_ok) begin
        gnt_idx <= win;
        gnt_vld <= found;
        bus.master_granted <= found ? MASTERS'(1) << win : '0;
        if (found && (win != gnt_idx || !gnt_vld)) rr_ptr <= win;
      end
      dph_idx <= gnt_idx;
      dph_vld <= gnt_vld && bus.slv_HSEL && bus.slv_HTRANS != IDLE;
    end
endmodule

// File: tb/tb_peripheral_msi_slave_port_apb4.sv
// tb_peripheral_msi_slave_port_apb4: directed scenarios plus random traffic against a score-based arbiter model
module tb_peripheral_msi_slave_port_apb4;
  localparam int M = 5;
  localparam int PLEN = 64;
  localparam int XLEN = 64;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int checks = 0;
  int failures = 0;
  bit m_vld, m_dvld;
  int m_idx, m_didx, m_rr;
  peripheral_msi_slave_port_apb4_if #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(M)) bus();
  peripheral_msi_slave_port_apb4 #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(M), .SLAVES(5)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus));
  always #5 HCLK = ~HCLK;
  // winner = best score, score = priority first, then closeness after the last winner
  function automatic int pick();
    int w = -1;
    int bs = -1;
    int s;
    for (int i = 0; i < M; i++)
      if (bus.mst_HSEL[i]) begin
        s = int'(bus.mst_priority[i]) * M + (M - 1 - ((i - m_rr - 1 + 2 * M) % M));
        if (s > bs) begin bs = s; w = i; end
      end
    return w;
  endfunction
  function automatic logic [M-1:0] exp_gnt();
    return m_vld ? M'(1) << m_idx : '0;
  endfunction
  task automatic model_reset();
    m_vld = 0; m_dvld = 0; m_idx = 0; m_didx = 0; m_rr = M - 1;
  endtask
  task automatic step();
    bit n_vld = m_vld, n_dvld = m_dvld;
    int n_idx = m_idx, n_didx = m_didx, n_rr = m_rr, w;
    if (bus.slv_HREADYOUT) begin
      n_dvld = m_vld && bus.mst_HSEL[m_idx] && bus.mst_HTRANS[m_idx] != 2'b00;
      n_didx = m_idx;
      if (!m_vld || !bus.mst_HSEL[m_idx] || bus.can_switch[m_idx]) begin
        w = pick();
        n_vld = w >= 0;
        if (w >= 0) begin
          if (w != m_idx || !m_vld) n_rr = w;
          n_idx = w;
        end
      end
    end
    @(posedge HCLK);
    #1;
    if (HRESET) model_reset();
    else begin
      m_vld = n_vld; m_dvld = n_dvld; m_idx = n_idx; m_didx = n_didx; m_rr = n_rr;
    end
  endtask
  task automatic clear_inputs();
    for (int i = 0; i < M; i++) begin
      bus.mst_priority[i] = 3'd3;
      bus.mst_HADDR[i] = {$urandom, $urandom};
      bus.mst_HWDATA[i] = {$urandom, $urandom};
      bus.mst_HSIZE[i] = 3'd3;
      bus.mst_HBURST[i] = 3'd0;
      bus.mst_HPROT[i] = 4'h3;
      bus.mst_HTRANS[i] = 2'b10;
    end
    bus.mst_HSEL = '0;
    bus.mst_HWRITE = '0;
    bus.mst_HMASTLOCK = '0;
    bus.mst_HREADY = '1;
    bus.can_switch = '0;
    bus.slv_HRDATA = '0;
    bus.slv_HREADYOUT = 1'b1;
    bus.slv_HRESP = 1'b0;
  endtask
  task automatic apply_reset();
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    clear_inputs();
    bus.mst_HSEL = 5'b01010;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    checks++; if (bus.master_granted !== 5'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=00000", bus.master_granted); end
    checks++; if (bus.slv_HTRANS !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%b exp=00", bus.slv_HTRANS); end
    checks++; if (bus.slv_HREADY !== 1'b1 || bus.slv_HSEL !== 1'b0) begin failures++; $display("FAIL reset_hready_hsel got=%b%b exp=10", bus.slv_HREADY, bus.slv_HSEL); end
    checks++; if (bus.slv_HWDATA !== '0) begin failures++; $display("FAIL reset_hwdata got=%h exp=0", bus.slv_HWDATA); end
    HRESET = 1'b0;
    model_reset();
    bus.mst_HSEL = 5'b00100;
    step();
    checks++; if (bus.master_granted !== 5'b00100) begin failures++; $display("FAIL reset_first_grant got=%b exp=00100", bus.master_granted); end
    checks++; if (bus.slv_HADDR !== bus.mst_HADDR[2]) begin failures++; $display("FAIL reset_first_addr got=%h exp=%h", bus.slv_HADDR, bus.mst_HADDR[2]); end
  endtask
  task automatic test_priority();
    bus.mst_HSEL = 5'b01010;
    bus.mst_priority[1] = 3'd2;
    bus.mst_priority[3] = 3'd6;
    step();
    checks++; if (bus.master_granted !== 5'b01000) begin failures++; $display("FAIL prio_high got=%b exp=01000", bus.master_granted); end
    bus.mst_HSEL[3] = 1'b0;
    step();
    checks++; if (bus.master_granted !== 5'b00010) begin failures++; $display("FAIL prio_drop got=%b exp=00010", bus.master_granted); end
  endtask
  task automatic test_round_robin();
    int order [5] = '{0, 2, 4, 0, 2};
    clear_inputs();
    apply_reset();
    bus.mst_HSEL = 5'b10101;
    bus.can_switch = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.master_granted !== M'(1) << order[i]) begin failures++; $display("FAIL rr_order[%0d] got=%b exp=%0d", i, bus.master_granted, order[i]); end
      checks++; if (bus.master_granted !== exp_gnt()) begin failures++; $display("FAIL rr_model[%0d] got=%b exp=%b", i, bus.master_granted, exp_gnt()); end
    end
  endtask
  task automatic test_locked_burst();
    clear_inputs();
    apply_reset();
    bus.mst_HSEL = 5'b00010;
    bus.mst_HBURST[1] = 3'b011;
    bus.mst_HMASTLOCK[1] = 1'b1;
    step();
    checks++; if (bus.master_granted !== 5'b00010) begin failures++; $display("FAIL lock_start got=%b exp=00010", bus.master_granted); end
    bus.mst_HSEL[4] = 1'b1;
    bus.mst_priority[4] = 3'd7;
    bus.mst_HTRANS[1] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.master_granted !== 5'b00010) begin failures++; $display("FAIL lock_hold[%0d] got=%b exp=00010", i, bus.master_granted); end
      checks++; if (bus.slv_HBURST !== 3'b011 || bus.slv_HTRANS !== 2'b11 || bus.slv_HMASTLOCK !== 1'b1) begin failures++; $display("FAIL lock_ctrl[%0d] got=%b/%b/%b exp=011/11/1", i, bus.slv_HBURST, bus.slv_HTRANS, bus.slv_HMASTLOCK); end
    end
    bus.can_switch[1] = 1'b1;
    step();
    checks++; if (bus.master_granted !== 5'b10000) begin failures++; $display("FAIL lock_release got=%b exp=10000", bus.master_granted); end
  endtask
  task automatic test_wait_states();
    logic [XLEN-1:0] wd, rd;
    clear_inputs();
    apply_reset();
    wd = {$urandom, $urandom};
    rd = {$urandom, $urandom};
    bus.mst_HWDATA[0] = wd;
    bus.mst_HWRITE[0] = 1'b1;
    bus.mst_HSEL = 5'b00001;
    step();
    checks++; if (bus.master_granted !== 5'b00001) begin failures++; $display("FAIL ws_grant got=%b exp=00001", bus.master_granted); end
    bus.mst_HSEL[1] = 1'b1;
    step();
    bus.slv_HREADYOUT = 1'b0;
    bus.slv_HRDATA = rd;
    bus.slv_HRESP = 1'b1;
    bus.can_switch[0] = 1'b1;
    #1;
    checks++; if (bus.slv_HWDATA !== wd) begin failures++; $display("FAIL ws_wdata got=%h exp=%h", bus.slv_HWDATA, wd); end
    checks++; if (bus.mst_HRDATA !== rd || bus.mst_HREADYOUT !== 1'b0 || bus.mst_HRESP !== 1'b1) begin failures++; $display("FAIL ws_response got=%h/%b/%b exp=%h/0/1", bus.mst_HRDATA, bus.mst_HREADYOUT, bus.mst_HRESP, rd); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.master_granted !== 5'b00001 || bus.slv_HWDATA !== wd) begin failures++; $display("FAIL ws_frozen[%0d] got=%b/%h exp=00001/%h", i, bus.master_granted, bus.slv_HWDATA, wd); end
    end
    bus.slv_HREADYOUT = 1'b1;
    bus.slv_HRESP = 1'b0;
    step();
    checks++; if (bus.master_granted !== 5'b00010) begin failures++; $display("FAIL ws_handover got=%b exp=00010", bus.master_granted); end
    checks++; if (bus.slv_HADDR !== bus.mst_HADDR[1] || bus.slv_HWDATA !== wd) begin failures++; $display("FAIL ws_overlap got=%h/%h exp=%h/%h", bus.slv_HADDR, bus.slv_HWDATA, bus.mst_HADDR[1], wd); end
  endtask
  task automatic test_reset_mid();
    step();
    bus.mst_HREADY[1] = 1'b0;
    #1;
    checks++; if (bus.slv_HREADY !== 1'b0) begin failures++; $display("FAIL mid_dphase got=%b exp=0", bus.slv_HREADY); end
    HRESET = 1'b1;
    #1;
    checks++; if (bus.master_granted !== 5'b0 || bus.slv_HREADY !== 1'b1 || bus.slv_HSEL !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%b/%b exp=00000/1/0", bus.master_granted, bus.slv_HREADY, bus.slv_HSEL); end
    #1;
    HRESET = 1'b0;
    model_reset();
    bus.mst_HSEL = 5'b01001;
    bus.mst_priority[3] = 3'd3;
    step();
    checks++; if (bus.master_granted !== 5'b00001) begin failures++; $display("FAIL mid_tie_m0 got=%b exp=00001", bus.master_granted); end
  endtask
  task automatic test_random();
    logic [M-1:0] eg;
    logic [1:0] et;
    logic eh, er;
    logic [XLEN-1:0] ew;
    clear_inputs();
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < M; i++) begin
        bus.mst_priority[i] = 3'($urandom_range(0, 7));
        bus.mst_HTRANS[i] = 2'($urandom_range(0, 3));
        bus.mst_HWDATA[i] = {$urandom, $urandom};
      end
      bus.mst_HSEL = M'($urandom);
      bus.can_switch = M'($urandom);
      bus.mst_HREADY = M'($urandom);
      bus.slv_HREADYOUT = $urandom_range(0, 3) != 0;
      step();
      eg = exp_gnt();
      et = m_vld ? bus.mst_HTRANS[m_idx] : 2'b00;
      eh = m_vld && bus.mst_HSEL[m_idx];
      er = m_dvld ? bus.mst_HREADY[m_didx] : 1'b1;
      ew = m_dvld ? bus.mst_HWDATA[m_didx] : '0;
      checks++; if (bus.master_granted !== eg) begin failures++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", n, bus.master_granted, eg); end
      checks++; if (bus.slv_HSEL !== eh || bus.slv_HTRANS !== et) begin failures++; $display("FAIL rnd_sel_trans[%0d] got=%b/%b exp=%b/%b", n, bus.slv_HSEL, bus.slv_HTRANS, eh, et); end
      checks++; if (bus.slv_HADDR !== bus.mst_HADDR[m_vld ? m_idx : 0]) begin failures++; $display("FAIL rnd_addr[%0d] got=%h", n, bus.slv_HADDR); end
      checks++; if (bus.slv_HREADY !== er || bus.slv_HWDATA !== ew) begin failures++; $display("FAIL rnd_dphase[%0d] got=%b/%h exp=%b/%h", n, bus.slv_HREADY, bus.slv_HWDATA, er, ew); end
    end
  endtask
  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_locked_burst();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
